wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback datapath for the RV32I core.
- Captures memory-stage results, aligns and extends load data, and selects the writeback source.
- Drives the register file write port (destination address, write data, write enable).
- Also exports a forwarding tap for the hazard/bypass unit and a retired-instruction counter.

---
 rtl/core_pkg.sv | 19 +
 rtl/load_extend.sv | 45 ++++
 rtl/wb_stage.sv | 99 +++++++++
 tb/tb_wb_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: writeback source encoding and load funct3 codes.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_RSV = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension; purely combinational.
module load_extend
  import core_pkg::*;
(
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; halfword offset ignores off[0]
  always_comb begin
    byte_s = mem_rdata[7:0];
    half_s = mem_rdata[15:0];
    case (off)
      2'd0:    byte_s = mem_rdata[7:0];
      2'd1:    byte_s = mem_rdata[15:8];
      2'd2:    byte_s = mem_rdata[23:16];
      2'd3:    byte_s = mem_rdata[31:24];
      default: byte_s = mem_rdata[7:0];
    endcase
    if (off[1]) begin
      half_s = mem_rdata[31:16];
    end else begin
      half_s = mem_rdata[15:0];
    end
  end

  // Extension by load type; unknown encodings pass the whole word through
  always_comb begin
    ext_data = mem_rdata;
    case (funct3)
      F3_LB:   ext_data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH:   ext_data = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_s};
      F3_LW:   ext_data = mem_rdata;
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: register file write port,
// bypass tap and retired-instruction counter.
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [4:0]       rd_in,
  input  logic             reg_wen_in,
  input  logic [1:0]       wb_sel,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  pc_plus4,
  output logic [4:0]       addr_d,
  output logic [XLEN-1:0]  data_d,
  output logic             reg_wen,
  output logic             wb_valid,
  output logic             fwd_en,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  load_data_s;
  logic [XLEN-1:0]  wb_data_s;
  logic             wen_s;
  logic             retire_s;

  logic [4:0]       addr_d_r;
  logic [XLEN-1:0]  data_d_r;
  logic             reg_wen_r;
  logic             wb_valid_r;
  logic [CNT_W-1:0] instret_r;

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .off       (alu_result[1:0]),
    .funct3    (funct3),
    .ext_data  (load_data_s)
  );

  // Writeback source select; the reserved encoding falls back to the ALU
  always_comb begin
    wb_data_s = alu_result;
    case (wb_sel_e'(wb_sel))
      WB_ALU:  wb_data_s = alu_result;
      WB_MEM:  wb_data_s = load_data_s;
      WB_PC4:  wb_data_s = pc_plus4;
      WB_RSV:  wb_data_s = alu_result;
      default: wb_data_s = alu_result;
    endcase
  end

  assign wen_s    = in_valid & reg_wen_in & (rd_in != 5'd0);
  // An instruction retires when it leaves the stage, not while it is held
  assign retire_s = wb_valid_r & ~stall & ~flush;

  // Pipeline register: rst > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      reg_wen_r  <= 1'b0;
      addr_d_r   <= 5'd0;
      data_d_r   <= {XLEN{1'b0}};
    end else if (flush) begin
      wb_valid_r <= 1'b0;
      reg_wen_r  <= 1'b0;
    end else if (!stall) begin
      wb_valid_r <= in_valid;
      reg_wen_r  <= wen_s;
      addr_d_r   <= rd_in;
      data_d_r   <= wb_data_s;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign addr_d   = addr_d_r;
  assign data_d   = data_d_r;
  assign reg_wen  = reg_wen_r;
  assign wb_valid = wb_valid_r;
  assign instret  = instret_r;
  assign fwd_en   = reg_wen_r & (addr_d_r != 5'd0);
  assign fwd_data = data_d_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, reg_wen_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [31:0] alu_result, mem_rdata, pc_plus4;
  logic [4:0]  addr_d;
  logic [31:0] data_d, fwd_data;
  logic        reg_wen, wb_valid, fwd_en;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_err = 0;
  longint exp_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rd_in(rd_in), .reg_wen_in(reg_wen_in), .wb_sel(wb_sel), .funct3(funct3),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4),
    .addr_d(addr_d), .data_d(data_d), .reg_wen(reg_wen), .wb_valid(wb_valid),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .instret(instret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu);
    in_valid   = v;
    reg_wen_in = 1'b1;
    rd_in      = rd;
    wb_sel     = sel;
    funct3     = f3;
    alu_result = alu;
  endtask

  logic [2:0]  ld_f3  [7];
  logic [1:0]  ld_off [7];
  logic [31:0] ld_exp [7];

  initial begin
    ld_f3[0] = 3'b000; ld_off[0] = 2'd0; ld_exp[0] = 32'hFFFF_FF81;
    ld_f3[1] = 3'b100; ld_off[1] = 2'd0; ld_exp[1] = 32'h0000_0081;
    ld_f3[2] = 3'b000; ld_off[2] = 2'd1; ld_exp[2] = 32'h0000_007F;
    ld_f3[3] = 3'b001; ld_off[3] = 2'd2; ld_exp[3] = 32'hFFFF_80FF;
    ld_f3[4] = 3'b101; ld_off[4] = 2'd3; ld_exp[4] = 32'h0000_80FF;
    ld_f3[5] = 3'b010; ld_off[5] = 2'd2; ld_exp[5] = 32'h80FF_7F81;
    ld_f3[6] = 3'b011; ld_off[6] = 2'd1; ld_exp[6] = 32'h80FF_7F81;

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 2'd0, 3'b000, 32'h0);
    mem_rdata = 32'h80FF_7F81;
    pc_plus4  = 32'h0000_0104;
    tick();
    tick();
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_addr_d", {59'd0, addr_d}, 64'd0);
    chk("rst_data_d", {32'd0, data_d}, 64'd0);
    chk("rst_reg_wen", {63'd0, reg_wen}, 64'd0);
    chk("rst_fwd_en", {63'd0, fwd_en}, 64'd0);
    chk("rst_instret", instret, 64'd0);

    // Scenario 1: ALU writeback
    rst = 1'b0;
    drive(1'b1, 5'd5, 2'd0, 3'b010, 32'h1234_5678);
    tick();
    exp_cnt = 0;
    chk("s1_addr_d", {59'd0, addr_d}, 64'd5);
    chk("s1_data_d", {32'd0, data_d}, 64'h1234_5678);
    chk("s1_reg_wen", {63'd0, reg_wen}, 64'd1);
    chk("s1_fwd_en", {63'd0, fwd_en}, 64'd1);
    chk("s1_fwd_data", {32'd0, fwd_data}, 64'h1234_5678);
    chk("s1_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("s1_instret0", instret, exp_cnt);

    // Scenario 2: load extraction, upper ALU bits must not affect the offset
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'd10 + 5'(i), 2'd1, ld_f3[i], {30'h0400_0000, ld_off[i]});
      tick();
      exp_cnt++;
      chk($sformatf("s2_load%0d_data", i), {32'd0, data_d}, {32'd0, ld_exp[i]});
      chk($sformatf("s2_load%0d_instret", i), instret, exp_cnt);
    end
    chk("s2_addr_d", {59'd0, addr_d}, 64'd16);

    // Scenario 3: JAL to rd=1, then to rd=0
    drive(1'b1, 5'd1, 2'd2, 3'b000, 32'hDEAD_BEEF);
    tick();
    exp_cnt++;
    chk("s3_jal_data", {32'd0, data_d}, 64'h104);
    chk("s3_jal_wen", {63'd0, reg_wen}, 64'd1);
    drive(1'b1, 5'd0, 2'd2, 3'b000, 32'hDEAD_BEEF);
    tick();
    exp_cnt++;
    chk("s3_x0_wen", {63'd0, reg_wen}, 64'd0);
    chk("s3_x0_fwd", {63'd0, fwd_en}, 64'd0);
    chk("s3_x0_valid", {63'd0, wb_valid}, 64'd1);
    chk("s3_x0_instret", instret, exp_cnt);

    // Scenario 4: capture then 3 stall cycles
    drive(1'b1, 5'd7, 2'd0, 3'b000, 32'hA5A5_0F0F);
    tick();
    exp_cnt++;
    chk("s4_x0_retired", instret, exp_cnt);
    drive(1'b1, 5'd9, 2'd0, 3'b000, 32'h5555_AAAA);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s4_hold%0d_addr", i), {59'd0, addr_d}, 64'd7);
      chk($sformatf("s4_hold%0d_data", i), {32'd0, data_d}, 64'hA5A5_0F0F);
      chk($sformatf("s4_hold%0d_wen", i), {63'd0, reg_wen}, 64'd1);
      chk($sformatf("s4_hold%0d_instret", i), instret, exp_cnt);
    end
    stall = 1'b0;
    drive(1'b0, 5'd9, 2'd0, 3'b000, 32'h5555_AAAA);
    tick();
    exp_cnt++;
    chk("s4_release_instret", instret, exp_cnt);
    chk("s4_bubble_valid", {63'd0, wb_valid}, 64'd0);
    chk("s4_bubble_wen", {63'd0, reg_wen}, 64'd0);

    // Reserved select behaves as ALU
    drive(1'b1, 5'd3, 2'd3, 3'b000, 32'h0BAD_F00D);
    tick();
    chk("rsv_data", {32'd0, data_d}, 64'h0BAD_F00D);
    chk("rsv_instret", instret, exp_cnt);

    // Scenario 5: flush with stall
    drive(1'b1, 5'd4, 2'd0, 3'b000, 32'h0000_4444);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("s5_valid", {63'd0, wb_valid}, 64'd0);
    chk("s5_wen", {63'd0, reg_wen}, 64'd0);
    chk("s5_fwd", {63'd0, fwd_en}, 64'd0);
    chk("s5_instret", instret, exp_cnt);

    // Scenario 6: reset while a valid write is held
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd6, 2'd0, 3'b000, 32'h1111_2222);
    tick();
    chk("s6_cap_wen", {63'd0, reg_wen}, 64'd1);
    stall = 1'b1;
    tick();
    chk("s6_held_data", {32'd0, data_d}, 64'h1111_2222);
    rst = 1'b1;
    tick();
    chk("s6_rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("s6_rst_addr", {59'd0, addr_d}, 64'd0);
    chk("s6_rst_data", {32'd0, data_d}, 64'd0);
    chk("s6_rst_wen", {63'd0, reg_wen}, 64'd0);
    chk("s6_rst_instret", instret, 64'd0);
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 5'd5, 2'd0, 3'b000, 32'h1234_5678);
    tick();
    chk("s6_after_addr", {59'd0, addr_d}, 64'd5);
    chk("s6_after_data", {32'd0, data_d}, 64'h1234_5678);
    chk("s6_after_wen", {63'd0, reg_wen}, 64'd1);
    chk("s6_after_instret0", instret, 64'd0);
    drive(1'b0, 5'd0, 2'd0, 3'b000, 32'h0);
    tick();
    chk("s6_after_instret1", instret, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
